// File: rtl/mul_div_unit.sv
// Iterative radix-2 RV64M multiply/divide unit: one result bit per clock,
// with operands latched at Start and a registered Result/DivZero written on entry to DONE.
module mul_div_unit #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic             Kill,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             DivZero
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE_W;
  endfunction

  state_t             state_r;
  logic [WIDTH-1:0]   a_r, b_r, md_r, rem_r, result_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [2:0]         op_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               neg_r, rneg_r, busy_r, done_r, div_zero_r;

  logic               signed_a_s, signed_b_s, neg_a_s, neg_b_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, spec_result_s;
  logic               div_zero_s, div_ovf_s;

  // Operand signedness, magnitudes and the two divide corner cases.
  always_comb begin
    signed_a_s    = (op_r == 3'b001) | (op_r == 3'b010) | (op_r[2] & ~op_r[0]);
    signed_b_s    = (op_r == 3'b001) | (op_r[2] & ~op_r[0]);
    neg_a_s       = signed_a_s & a_r[WIDTH-1];
    neg_b_s       = signed_b_s & b_r[WIDTH-1];
    mag_a_s       = neg_a_s ? negate(a_r) : a_r;
    mag_b_s       = neg_b_s ? negate(b_r) : b_r;
    div_zero_s    = op_r[2] & (b_r == ZERO_W);
    div_ovf_s     = op_r[2] & ~op_r[0] & (a_r == MIN_INT) & (b_r == ONES_W);
    // op_r[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero_s) begin
      spec_result_s = op_r[1] ? a_r : ONES_W;
    end else begin
      spec_result_s = op_r[1] ? ZERO_W : MIN_INT;
    end
  end

  logic [WIDTH:0]   mul_sum_s, div_shift_s;
  logic [WIDTH-1:0] div_diff_s;
  logic             div_ge_s;

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                  (prod_r[0] ? {1'b0, md_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {rem_r, prod_r[WIDTH-1]};
    div_ge_s    = (div_shift_s >= {1'b0, md_r});
    div_diff_s  = div_shift_s[WIDTH-1:0] - md_r;
  end

  logic [2*WIDTH-1:0] prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, fix_result_s;

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod_fix_s = neg_r ? (~prod_r + ONE_2W) : prod_r;
    quo_fix_s  = neg_r ? negate(prod_r[WIDTH-1:0]) : prod_r[WIDTH-1:0];
    rem_fix_s  = rneg_r ? negate(rem_r) : rem_r;
    case (op_r)
      3'b000:                 fix_result_s = prod_fix_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_result_s = prod_fix_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_result_s = quo_fix_s;
      3'b110, 3'b111:         fix_result_s = rem_fix_s;
      default:                fix_result_s = ZERO_W;
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      a_r        <= ZERO_W;
      b_r        <= ZERO_W;
      md_r       <= ZERO_W;
      rem_r      <= ZERO_W;
      result_r   <= ZERO_W;
      prod_r     <= {(2*WIDTH){1'b0}};
      op_r       <= 3'b000;
      cnt_r      <= {CNT_W{1'b0}};
      neg_r      <= 1'b0;
      rneg_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (Kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (Start) begin
            a_r        <= A;
            b_r        <= B;
            op_r       <= Funct3;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_PREP;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        ST_PREP: begin
          if (Kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (div_zero_s | div_ovf_s) begin
            result_r   <= spec_result_s;
            div_zero_r <= div_zero_s;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state_r    <= ST_DONE;
          end else begin
            // Multiply shifts the multiplier out of the low half; divide shifts the dividend out.
            md_r    <= op_r[2] ? mag_b_s : mag_a_s;
            prod_r  <= {ZERO_W, (op_r[2] ? mag_a_s : mag_b_s)};
            rem_r   <= ZERO_W;
            neg_r   <= neg_a_s ^ neg_b_s;
            rneg_r  <= neg_a_s;
            cnt_r   <= CNT_LOAD;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (Kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            if (op_r[2]) begin
              rem_r  <= div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
              prod_r <= {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-2:0], div_ge_s};
            end else begin
              prod_r <= {mul_sum_s, prod_r[WIDTH-1:1]};
            end
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end
        ST_FIX: begin
          if (Kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            result_r <= fix_result_s;
            done_r   <= 1'b1;
            busy_r   <= 1'b0;
            state_r  <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign Result  = result_r;
  assign DivZero = div_zero_r;

endmodule
